// File: rtl/pifo_cpu_access_ctrl.sv
// pifo_cpu_access_ctrl
// Bridges a host request/response port onto the PIFO calendar CPU access
// strobes. One transaction is outstanding at a time: a request is captured,
// issued to the calendar as a single registered strobe, and then the block
// waits for the matching completion or for a timeout before responding.
//
// Optional feature: define PIFO_CPU_ACCESS_STATS_EN to add saturating 16-bit
// counters of successful reads, successful writes and error responses.
`timescale 1ns/1ps

module pifo_cpu_access_ctrl #(
    parameter int PIFO_CALENDAR_SIZE        = 1024,
    parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
    parameter int PIFO_ROOT_WIDTH           = 32,
    parameter int TIMEOUT_CYCLES            = 255
) (
    input  logic                                 clk,
    input  logic                                 rstn,

    input  logic                                 host_req_valid,
    output logic                                 host_req_ready,
    input  logic                                 host_req_wr,
    input  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] host_req_addr,
    input  logic [PIFO_ROOT_WIDTH-1:0]           host_req_wdata,

    output logic                                 host_resp_valid,
    input  logic                                 host_resp_ready,
    output logic [PIFO_ROOT_WIDTH-1:0]           host_resp_rdata,
    output logic                                 host_resp_err,

    output logic                                 cpu_rd_valid,
    output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_rd_addr,
    input  logic                                 cpu_rd_result_valid,
    input  logic [PIFO_ROOT_WIDTH-1:0]           cpu_rd_result,

    output logic                                 cpu_wr_valid,
    output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_wr_addr,
    output logic [PIFO_ROOT_WIDTH-1:0]           cpu_wr_data,
    input  logic                                 cpu_wr_result_valid
`ifdef PIFO_CPU_ACCESS_STATS_EN
    ,
    output logic [15:0]                          stat_rd_cnt,
    output logic [15:0]                          stat_wr_cnt,
    output logic [15:0]                          stat_err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Last counter value before the wait is declared timed out.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                               state_q,   state_d;
    logic                                 reqReady_q, reqReady_d;
    logic                                 reqWr_q,   reqWr_d;
    logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] reqAddr_q, reqAddr_d;
    logic [PIFO_ROOT_WIDTH-1:0]           reqData_q, reqData_d;
    logic [PIFO_ROOT_WIDTH-1:0]           rdata_q,   rdata_d;
    logic                                 err_q,     err_d;
    logic [7:0]                           waitCnt_q, waitCnt_d;
    logic                                 rdValid_q, rdValid_d;
    logic                                 wrValid_q, wrValid_d;

    logic        reqFire;
    logic        addrInRange;
    logic        rdDone;
    logic        wrDone;
    logic [31:0] addrExt;

    // Handshake is qualified by the registered ready, which is low in reset
    // and only high while the FSM sits in IDLE.
    assign reqFire     = host_req_valid & reqReady_q;
    assign addrExt     = 32'(host_req_addr);
    assign addrInRange = (addrExt < 32'(PIFO_CALENDAR_SIZE));

    // Only the completion that matches the outstanding type counts.
    assign rdDone = ~reqWr_q & cpu_rd_result_valid;
    assign wrDone =  reqWr_q & cpu_wr_result_valid;

    // State register together with all captured request/response fields.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            reqReady_q <= 1'b0;
            reqWr_q    <= 1'b0;
            reqAddr_q  <= '0;
            reqData_q  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            waitCnt_q  <= '0;
            rdValid_q  <= 1'b0;
            wrValid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            reqReady_q <= reqReady_d;
            reqWr_q    <= reqWr_d;
            reqAddr_q  <= reqAddr_d;
            reqData_q  <= reqData_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            waitCnt_q  <= waitCnt_d;
            rdValid_q  <= rdValid_d;
            wrValid_q  <= wrValid_d;
        end
    end

    // Next-state logic: capture on handshake, range check, timeout and
    // completion handling. Calendar strobes are computed one cycle early so
    // they come straight out of flops during ISSUE.
    always_comb begin
        state_d   = state_q;
        reqWr_d   = reqWr_q;
        reqAddr_d = reqAddr_q;
        reqData_d = reqData_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        waitCnt_d = waitCnt_q;
        rdValid_d = 1'b0;
        wrValid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqFire) begin
                    reqWr_d   = host_req_wr;
                    reqAddr_d = host_req_addr;
                    reqData_d = host_req_wdata;
                    if (addrInRange) begin
                        state_d   = ISSUE;
                        rdValid_d = ~host_req_wr;
                        wrValid_d =  host_req_wr;
                    end else begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d   = WAIT;
                waitCnt_d = '0;
            end
            WAIT: begin
                if (rdDone) begin
                    state_d = RESP;
                    rdata_d = cpu_rd_result;
                    err_d   = 1'b0;
                end else if (wrDone) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end else if (waitCnt_q == TIMEOUT_LAST) begin
                    state_d   = RESP;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    waitCnt_d = waitCnt_q + 8'd1;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            RESP: begin
                if (host_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        reqReady_d = (state_d == IDLE);
    end

    // Output decode: everything is driven from registers.
    always_comb begin
        host_req_ready  = reqReady_q;
        host_resp_valid = (state_q == RESP);
        host_resp_rdata = rdata_q;
        host_resp_err   = err_q;
        cpu_rd_valid    = rdValid_q;
        cpu_rd_addr     = reqAddr_q;
        cpu_wr_valid    = wrValid_q;
        cpu_wr_addr     = reqAddr_q;
        cpu_wr_data     = reqData_q;
    end

`ifdef PIFO_CPU_ACCESS_STATS_EN
    logic [15:0] statRd_q, statWr_q, statErr_q;
    logic        incRd, incWr, incErr;

    // Classify each entry into RESP as a good read, good write or error.
    always_comb begin
        incRd  = (state_q == WAIT) && (state_d == RESP) && !err_d && !reqWr_q;
        incWr  = (state_q == WAIT) && (state_d == RESP) && !err_d &&  reqWr_q;
        incErr = (state_q != RESP) && (state_d == RESP) &&  err_d;
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            statRd_q  <= '0;
            statWr_q  <= '0;
            statErr_q <= '0;
        end else begin
            if (incRd && (statRd_q != 16'hFFFF)) begin
                statRd_q <= statRd_q + 16'd1;
            end
            if (incWr && (statWr_q != 16'hFFFF)) begin
                statWr_q <= statWr_q + 16'd1;
            end
            if (incErr && (statErr_q != 16'hFFFF)) begin
                statErr_q <= statErr_q + 16'd1;
            end
        end
    end

    assign stat_rd_cnt  = statRd_q;
    assign stat_wr_cnt  = statWr_q;
    assign stat_err_cnt = statErr_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pifo_cpu_access_ctrl.sv
// tb_pifo_cpu_access_ctrl
// Directed bench for pifo_cpu_access_ctrl. The index width is widened to 11
// bits so that address 1024 can be presented against a 1024-entry calendar,
// and the timeout is shortened to 16 cycles. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
`timescale 1ns/1ps

module tb_pifo_cpu_access_ctrl;

    localparam int SIZE = 1024;
    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          host_req_valid;
    logic          host_req_ready;
    logic          host_req_wr;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_wdata;
    logic          host_resp_valid;
    logic          host_resp_ready;
    logic [DW-1:0] host_resp_rdata;
    logic          host_resp_err;
    logic          cpu_rd_valid;
    logic [AW-1:0] cpu_rd_addr;
    logic          cpu_rd_result_valid;
    logic [DW-1:0] cpu_rd_result;
    logic          cpu_wr_valid;
    logic [AW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_wr_result_valid;
`ifdef PIFO_CPU_ACCESS_STATS_EN
    logic [15:0]   statRdCnt;
    logic [15:0]   statWrCnt;
    logic [15:0]   statErrCnt;
`endif

    int testCount = 0;
    int failCount = 0;

    pifo_cpu_access_ctrl #(
        .PIFO_CALENDAR_SIZE        (SIZE),
        .PIFO_CALENDAR_INDEX_WIDTH (AW),
        .PIFO_ROOT_WIDTH           (DW),
        .TIMEOUT_CYCLES            (TO)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .host_req_valid      (host_req_valid),
        .host_req_ready      (host_req_ready),
        .host_req_wr         (host_req_wr),
        .host_req_addr       (host_req_addr),
        .host_req_wdata      (host_req_wdata),
        .host_resp_valid     (host_resp_valid),
        .host_resp_ready     (host_resp_ready),
        .host_resp_rdata     (host_resp_rdata),
        .host_resp_err       (host_resp_err),
        .cpu_rd_valid        (cpu_rd_valid),
        .cpu_rd_addr         (cpu_rd_addr),
        .cpu_rd_result_valid (cpu_rd_result_valid),
        .cpu_rd_result       (cpu_rd_result),
        .cpu_wr_valid        (cpu_wr_valid),
        .cpu_wr_addr         (cpu_wr_addr),
        .cpu_wr_data         (cpu_wr_data),
        .cpu_wr_result_valid (cpu_wr_result_valid)
`ifdef PIFO_CPU_ACCESS_STATS_EN
        ,
        .stat_rd_cnt         (statRdCnt),
        .stat_wr_cnt         (statWrCnt),
        .stat_err_cnt        (statErrCnt)
`endif
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Presents one request while the block is idle and completes the
    // handshake; returns one falling edge later, i.e. in the ISSUE cycle.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        host_req_valid = 1'b1;
        host_req_wr    = wr;
        host_req_addr  = addr;
        host_req_wdata = data;
        checkOutput("req_ready_idle", 32'(host_req_ready), 32'd1);
        @(negedge clk);
        host_req_valid = 1'b0;
    endtask

    // Accepts the pending response and checks the return to IDLE.
    task automatic consumeResponse(input string tag);
        host_resp_ready = 1'b1;
        @(negedge clk);
        host_resp_ready = 1'b0;
        checkOutput({tag, "_resp_gone"}, 32'(host_resp_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(host_req_ready), 32'd1);
    endtask

    // Checks every output against its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"},  32'(host_req_ready),  32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(host_resp_valid), 32'd0);
        checkOutput({tag, "_resp_rdata"}, host_resp_rdata,      32'd0);
        checkOutput({tag, "_resp_err"},   32'(host_resp_err),   32'd0);
        checkOutput({tag, "_rd_valid"},   32'(cpu_rd_valid),    32'd0);
        checkOutput({tag, "_wr_valid"},   32'(cpu_wr_valid),    32'd0);
        checkOutput({tag, "_rd_addr"},    32'(cpu_rd_addr),     32'd0);
        checkOutput({tag, "_wr_addr"},    32'(cpu_wr_addr),     32'd0);
        checkOutput({tag, "_wr_data"},    cpu_wr_data,          32'd0);
`ifdef PIFO_CPU_ACCESS_STATS_EN
        checkOutput({tag, "_stat_rd"},    32'(statRdCnt),       32'd0);
        checkOutput({tag, "_stat_wr"},    32'(statWrCnt),       32'd0);
        checkOutput({tag, "_stat_err"},   32'(statErrCnt),      32'd0);
`endif
    endtask

    // Directed scenario sequence.
    initial begin
        rstn                = 1'b1;
        host_req_valid      = 1'b0;
        host_req_wr         = 1'b0;
        host_req_addr       = '0;
        host_req_wdata      = '0;
        host_resp_ready     = 1'b0;
        cpu_rd_result_valid = 1'b0;
        cpu_rd_result       = '0;
        cpu_wr_result_valid = 1'b0;
        #2 rstn = 1'b0;

        // Reset state, then ready from the first edge after release.
        repeat (2) @(negedge clk);
        checkResetValues("por");
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(host_req_ready), 32'd1);

        // Read address 5, calendar answers one cycle after the strobe.
        applyStimulus(1'b0, 11'd5, 32'd0);
        checkOutput("rd_strobe",      32'(cpu_rd_valid),   32'd1);
        checkOutput("rd_strobe_addr", 32'(cpu_rd_addr),    32'd5);
        checkOutput("rd_no_wr",       32'(cpu_wr_valid),   32'd0);
        checkOutput("rd_busy",        32'(host_req_ready), 32'd0);
        @(negedge clk);
        checkOutput("rd_pulse_once",  32'(cpu_rd_valid),    32'd0);
        checkOutput("rd_no_resp_yet", 32'(host_resp_valid), 32'd0);
        cpu_rd_result_valid = 1'b1;
        cpu_rd_result       = 32'h8000_0ABC;
        @(negedge clk);
        cpu_rd_result_valid = 1'b0;
        cpu_rd_result       = '0;
        checkOutput("rd_resp_valid", 32'(host_resp_valid), 32'd1);
        checkOutput("rd_resp_rdata", host_resp_rdata,      32'h8000_0ABC);
        checkOutput("rd_resp_err",   32'(host_resp_err),   32'd0);
        consumeResponse("rd5");

        // Write to the last valid index; a stray read completion is ignored.
        applyStimulus(1'b1, 11'd1023, 32'hDEAD_BEEF);
        checkOutput("wr_strobe",      32'(cpu_wr_valid), 32'd1);
        checkOutput("wr_strobe_addr", 32'(cpu_wr_addr),  32'd1023);
        checkOutput("wr_strobe_data", cpu_wr_data,       32'hDEAD_BEEF);
        checkOutput("wr_no_rd",       32'(cpu_rd_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cpu_rd_result_valid = (i == 1);
            cpu_rd_result       = 32'h1111_2222;
            @(negedge clk);
            checkOutput("wr_pulse_once", 32'(cpu_wr_valid),    32'd0);
            checkOutput("wr_waiting",    32'(host_resp_valid), 32'd0);
        end
        cpu_rd_result_valid = 1'b0;
        cpu_wr_result_valid = 1'b1;
        @(negedge clk);
        cpu_wr_result_valid = 1'b0;
        checkOutput("wr_resp_valid", 32'(host_resp_valid), 32'd1);
        checkOutput("wr_resp_err",   32'(host_resp_err),   32'd0);
        checkOutput("wr_resp_rdata", host_resp_rdata,      32'd0);
        consumeResponse("wr1023");

        // Address one past the end: immediate error, no calendar strobe.
        applyStimulus(1'b0, 11'd1024, 32'd0);
        checkOutput("oor_no_rd",      32'(cpu_rd_valid),    32'd0);
        checkOutput("oor_no_wr",      32'(cpu_wr_valid),    32'd0);
        checkOutput("oor_resp_valid", 32'(host_resp_valid), 32'd1);
        checkOutput("oor_resp_err",   32'(host_resp_err),   32'd1);
        checkOutput("oor_resp_rdata", host_resp_rdata,      32'd0);
        consumeResponse("oor");
`ifdef PIFO_CPU_ACCESS_STATS_EN
        checkOutput("stat_rd_1",  32'(statRdCnt),  32'd1);
        checkOutput("stat_wr_1",  32'(statWrCnt),  32'd1);
        checkOutput("stat_err_1", 32'(statErrCnt), 32'd1);
`endif

        // Write that never completes: error after 16 WAIT cycles.
        applyStimulus(1'b1, 11'd7, 32'h0000_1111);
        checkOutput("to_strobe", 32'(cpu_wr_valid), 32'd1);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            checkOutput("to_waiting", 32'(host_resp_valid), 32'd0);
        end
        @(negedge clk);
        checkOutput("to_resp_valid", 32'(host_resp_valid), 32'd1);
        checkOutput("to_resp_err",   32'(host_resp_err),   32'd1);
        checkOutput("to_resp_rdata", host_resp_rdata,      32'd0);
        cpu_wr_result_valid = 1'b1;
        @(negedge clk);
        cpu_wr_result_valid = 1'b0;
        checkOutput("late_in_resp_valid", 32'(host_resp_valid), 32'd1);
        checkOutput("late_in_resp_err",   32'(host_resp_err),   32'd1);
        consumeResponse("timeout");
        cpu_wr_result_valid = 1'b1;
        cpu_rd_result_valid = 1'b1;
        @(negedge clk);
        cpu_wr_result_valid = 1'b0;
        cpu_rd_result_valid = 1'b0;
        checkOutput("late_in_idle_resp",  32'(host_resp_valid), 32'd0);
        checkOutput("late_in_idle_ready", 32'(host_req_ready),  32'd1);

        // Normal read right after the timeout.
        applyStimulus(1'b0, 11'd3, 32'd0);
        checkOutput("post_to_rd_strobe", 32'(cpu_rd_valid), 32'd1);
        checkOutput("post_to_rd_addr",   32'(cpu_rd_addr),  32'd3);
        @(negedge clk);
        cpu_rd_result_valid = 1'b1;
        cpu_rd_result       = 32'h1234_5678;
        @(negedge clk);
        cpu_rd_result_valid = 1'b0;
        cpu_rd_result       = '0;
        checkOutput("post_to_rd_valid", 32'(host_resp_valid), 32'd1);
        checkOutput("post_to_rd_rdata", host_resp_rdata,      32'h1234_5678);
        checkOutput("post_to_rd_err",   32'(host_resp_err),   32'd0);
        consumeResponse("post_to");

        // Completion on the very last WAIT cycle beats the timeout.
        applyStimulus(1'b1, 11'd8, 32'h0000_2222);
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            checkOutput("edge_waiting", 32'(host_resp_valid), 32'd0);
        end
        @(negedge clk);
        cpu_wr_result_valid = 1'b1;
        @(negedge clk);
        cpu_wr_result_valid = 1'b0;
        checkOutput("edge_resp_valid", 32'(host_resp_valid), 32'd1);
        checkOutput("edge_resp_err",   32'(host_resp_err),   32'd0);
        consumeResponse("edge");

        // Response held off for 10 cycles with a pending request and a
        // stray read completion.
        applyStimulus(1'b0, 11'd9, 32'd0);
        @(negedge clk);
        cpu_rd_result_valid = 1'b1;
        cpu_rd_result       = 32'hCAFE_0009;
        @(negedge clk);
        cpu_rd_result_valid = 1'b0;
        checkOutput("stall_resp_valid", 32'(host_resp_valid), 32'd1);
        host_req_valid = 1'b1;
        host_req_wr    = 1'b0;
        host_req_addr  = 11'd10;
        for (int i = 0; i < 10; i++) begin
            cpu_rd_result_valid = (i == 3);
            cpu_rd_result       = 32'h5555_5555;
            @(negedge clk);
            checkOutput("stall_valid",  32'(host_resp_valid), 32'd1);
            checkOutput("stall_rdata",  host_resp_rdata,      32'hCAFE_0009);
            checkOutput("stall_err",    32'(host_resp_err),   32'd0);
            checkOutput("stall_no_acc", 32'(host_req_ready),  32'd0);
            checkOutput("stall_no_rd",  32'(cpu_rd_valid),    32'd0);
        end
        cpu_rd_result_valid = 1'b0;
        host_req_valid      = 1'b0;
        consumeResponse("stall");

        // Reset asserted while waiting for a write completion.
        applyStimulus(1'b1, 11'd12, 32'hA5A5_A5A5);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkResetValues("mid_reset");
        cpu_wr_result_valid = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        cpu_wr_result_valid = 1'b0;
        checkOutput("after_reset_ready", 32'(host_req_ready),  32'd1);
        checkOutput("after_reset_resp",  32'(host_resp_valid), 32'd0);
        @(negedge clk);
        checkOutput("after_reset_resp2", 32'(host_resp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
